// File: rtl/sr_button_conditioner.sv
// Conditions two bouncy push-buttons into clean, non-overlapping set/reset pulses for a
// downstream SR latch, with conflict detection and a one-deep pending slot per channel.
module sr_button_conditioner #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic s_in,
  input  logic r_in,
  output logic s_out,
  output logic r_out,
  output logic q_model,
  output logic conflict,
  output logic busy
);

  typedef enum logic [1:0] {
    StIdle,
    StPulseS,
    StPulseR,
    StGap
  } state_e;

  localparam logic [7:0] DbLast    = 8'(DB_CYCLES);
  localparam logic [3:0] PulseLast = 4'(PULSE_LEN - 1);

  // Channel 0 is set, channel 1 is reset.
  logic [1:0]      w_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_db;
  logic [1:0]      r_db_prev;
  logic [1:0][7:0] r_cnt;
  logic [1:0]      w_req;
  logic [1:0]      w_any;
  logic [1:0]      r_pend;
  logic [3:0]      r_plen;
  state_e          r_state;

  assign w_raw = {r_in, s_in};
  assign w_req = r_db & ~r_db_prev;
  assign w_any = w_req | r_pend;

  // The level flips on the first differing sample after the run count has reached DB_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int c = 0; c < 2; c++) begin
        if (r_sync2[c] == r_db[c]) begin
          r_cnt[c] <= '0;
        end else if (r_cnt[c] == DbLast) begin
          r_db[c]  <= ~r_db[c];
          r_cnt[c] <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_pend   <= '0;
      r_plen   <= '0;
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      q_model  <= 1'b0;
      conflict <= 1'b0;
      busy     <= 1'b0;
    end else begin
      conflict <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any[0] && w_any[1]) begin
            conflict <= 1'b1;
            r_pend   <= '0;
          end else if (w_any[0]) begin
            r_state   <= StPulseS;
            s_out     <= 1'b1;
            busy      <= 1'b1;
            r_plen    <= PulseLast;
            r_pend[0] <= 1'b0;
          end else if (w_any[1]) begin
            r_state   <= StPulseR;
            r_out     <= 1'b1;
            busy      <= 1'b1;
            r_plen    <= PulseLast;
            r_pend[1] <= 1'b0;
          end
        end
        StPulseS, StPulseR: begin
          r_pend <= r_pend | w_req;
          if (r_plen == 4'd0) begin
            r_state <= StGap;
            s_out   <= 1'b0;
            r_out   <= 1'b0;
            q_model <= (r_state == StPulseS);
          end else begin
            r_plen <= r_plen - 4'd1;
          end
        end
        StGap: begin
          r_pend  <= r_pend | w_req;
          r_state <= StIdle;
          busy    <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Scoreboard bench: a timestamp-based model predicts pulse/conflict events; a negedge monitor
// pops and compares them, and also checks reset, overlap, pulse width, busy and latch Q.
module tb_sr_button_conditioner;

  localparam int DB   = 4;
  localparam int PL   = 2;
  localparam int MAXE = 16384;

  logic clk = 1'b0;
  logic rst;
  logic s_in;
  logic r_in;
  logic s_out;
  logic r_out;
  logic q_model;
  logic conflict;
  logic busy;

  sr_button_conditioner #(
    .DB_CYCLES(DB),
    .PULSE_LEN(PL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_in    (s_in),
    .r_in    (r_in),
    .s_out   (s_out),
    .r_out   (r_out),
    .q_model (q_model),
    .conflict(conflict),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, got, exp);
    end
  endtask

  // kind: 0 = set pulse starts, 1 = reset pulse starts, 2 = conflict flag
  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state
  bit xh [0:1][0:MAXE-1];
  int rst_edge = 0;
  bit mdb [0:1];
  int last_flip [0:1];
  bit prev_new [0:1];
  bit pend [0:1];
  int free_at = 0;
  int last_start = -100;

  // Debouncer input seen at edge k is the raw level sampled two edges earlier.
  function automatic bit samp(input int c, input int k);
    int j;
    j = k - 2;
    if (j <= rst_edge) return 1'b0;
    return xh[c][j];
  endfunction

  task automatic model_step();
    int k;
    bit a0, a1, all_diff;
    bit new_r [0:1];
    k = edge_n;
    if (k >= MAXE) begin
      $display("FAIL model_range: edge %0d beyond history %0d", k, MAXE);
      $fatal(1);
    end
    if (rst) begin
      rst_edge = k;
      for (int c = 0; c < 2; c++) begin
        mdb[c] = 1'b0;
        last_flip[c] = k;
        prev_new[c] = 1'b0;
        pend[c] = 1'b0;
      end
      free_at = 0;
      last_start = -100;
      return;
    end
    xh[0][k] = s_in;
    xh[1][k] = r_in;
    // Engine: requests visible before this edge are those whose level rose at the previous one.
    if (k < free_at) begin
      for (int c = 0; c < 2; c++) pend[c] = pend[c] | prev_new[c];
    end else begin
      a0 = prev_new[0] | pend[0];
      a1 = prev_new[1] | pend[1];
      if (a0 && a1) begin
        exp_q.push_back('{kind: 2, at: k});
        pend[0] = 1'b0;
        pend[1] = 1'b0;
      end else if (a0 || a1) begin
        exp_q.push_back('{kind: (a0 ? 0 : 1), at: k});
        free_at = k + PL + 2;
        last_start = k;
        if (a0) pend[0] = 1'b0;
        else pend[1] = 1'b0;
      end
    end
    // Debounce: flip once the last DB+1 samples since the previous flip all disagree.
    for (int c = 0; c < 2; c++) begin
      new_r[c] = 1'b0;
      if (k - last_flip[c] >= DB + 1) begin
        all_diff = 1'b1;
        for (int i = 0; i <= DB; i++) if (samp(c, k - i) == mdb[c]) all_diff = 1'b0;
        if (all_diff) begin
          mdb[c] = ~mdb[c];
          last_flip[c] = k;
          new_r[c] = mdb[c];
        end
      end
      prev_new[c] = new_r[c];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic pop_cmp(input int kind, input int at);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, required none", kind, at);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_edge", at, e.at);
  endtask

  // Monitor
  bit m_ps = 1'b0;
  bit m_pr = 1'b0;
  bit m_q = 1'b0;
  int m_run = 0;
  int mk;

  always @(negedge clk) begin
    mk = edge_n;
    if (rst) begin
      check("reset_outputs", int'({s_out, r_out, q_model, conflict, busy}), 0);
      exp_q.delete();
      m_ps = 1'b0;
      m_pr = 1'b0;
      m_q = 1'b0;
      m_run = 0;
    end else begin
      check("no_overlap", int'((s_out & r_out) | (m_ps & r_out) | (m_pr & s_out)), 0);
      if (s_out && !m_ps) pop_cmp(0, mk);
      if (r_out && !m_pr) pop_cmp(1, mk);
      if (conflict) pop_cmp(2, mk);
      if (s_out || r_out) m_run++;
      else if (m_ps || m_pr) begin
        check("pulse_len", m_run, PL);
        m_run = 0;
      end
      check("busy", int'(busy), int'(mk >= last_start && mk <= last_start + PL));
      if (s_out) m_q = 1'b1;
      else if (r_out) m_q = 1'b0;
      if (!s_out && !r_out) check("q_latch", int'(q_model), int'(m_q));
      m_ps = s_out;
      m_pr = r_out;
    end
  end

  int e0;
  int hold [0:1];
  int bnc [0:1];
  bit lvl [0:1];
  bit v [0:1];

  initial begin
    rst = 1'b1;
    s_in = 1'b0;
    r_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("idle_after_reset", int'({s_out, r_out, q_model, conflict, busy}), 0);

    // Single set request: latency and pulse shape
    e0 = edge_n + 1;
    s_in = 1'b1;
    wait_edge(e0 + 6);
    check("s_early", int'(s_out), 0);
    wait_edge(e0 + 7);
    check("s_e7", int'(s_out), 1);
    wait_edge(e0 + 8);
    check("s_e8", int'(s_out), 1);
    check("busy_e8", int'(busy), 1);
    wait_edge(e0 + 9);
    check("s_e9", int'(s_out), 0);
    check("q_e9", int'(q_model), 1);
    wait_edge(e0 + 10);
    check("busy_e10", int'(busy), 0);
    s_in = 1'b0;
    repeat (12) tick();

    // Simultaneous requests are discarded with a one-cycle conflict flag
    e0 = edge_n + 1;
    s_in = 1'b1;
    r_in = 1'b1;
    wait_edge(e0 + 7);
    check("conflict_on", int'(conflict), 1);
    wait_edge(e0 + 8);
    check("conflict_off", int'(conflict), 0);
    check("q_after_conflict", int'(q_model), 1);
    s_in = 1'b0;
    r_in = 1'b0;
    repeat (12) tick();

    // Short glitches never produce a pulse
    repeat (5) begin
      s_in = 1'b1;
      repeat (3) tick();
      s_in = 1'b0;
      repeat (2) tick();
    end
    repeat (12) tick();
    check("q_after_glitch", int'(q_model), 1);

    // Reset in the middle of a pulse
    e0 = edge_n + 1;
    s_in = 1'b1;
    wait_edge(e0 + 8);
    check("s_before_rst", int'(s_out), 1);
    rst = 1'b1;
    s_in = 1'b0;
    #1;
    check("rst_drops_s", int'(s_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_q", int'(q_model), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    check("quiet_after_rst", int'({s_out, r_out, busy}), 0);

    // Button held through reset is a new request after release
    s_in = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    e0 = edge_n + 1;
    wait_edge(e0 + 6);
    check("held_early", int'(s_out), 0);
    wait_edge(e0 + 7);
    check("held_e7", int'(s_out), 1);
    s_in = 1'b0;
    repeat (12) tick();

    // Reset request arriving during a set pulse goes pending
    e0 = edge_n + 1;
    s_in = 1'b1;
    tick();
    tick();
    r_in = 1'b1;
    wait_edge(e0 + 8);
    check("pend_s_e8", int'(s_out), 1);
    check("pend_r_e8", int'(r_out), 0);
    wait_edge(e0 + 9);
    check("pend_q_e9", int'(q_model), 1);
    wait_edge(e0 + 11);
    check("pend_r_e11", int'(r_out), 1);
    wait_edge(e0 + 12);
    check("pend_r_e12", int'(r_out), 1);
    wait_edge(e0 + 13);
    check("pend_r_e13", int'(r_out), 0);
    check("pend_q_e13", int'(q_model), 0);
    s_in = 1'b0;
    r_in = 1'b0;
    repeat (12) tick();

    // Random bounce on both buttons
    for (int c = 0; c < 2; c++) begin
      hold[c] = 0;
      bnc[c] = 0;
      lvl[c] = 1'b0;
    end
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (bnc[c] > 0) begin
          v[c] = 1'($urandom_range(0, 1));
          bnc[c]--;
        end else if (hold[c] > 0) begin
          v[c] = lvl[c];
          hold[c]--;
        end else begin
          lvl[c] = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(2, 30));
          bnc[c] = int'($urandom_range(0, 6));
          v[c] = lvl[c];
        end
      end
      s_in = v[0];
      r_in = v[1];
      if ($urandom_range(0, 1999) == 0) begin
        rst = 1'b1;
        repeat (int'($urandom_range(1, 3))) tick();
        rst = 1'b0;
      end
      tick();
    end

    s_in = 1'b0;
    r_in = 1'b0;
    repeat (2 * DB + PL + 12) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
